tlul_a_arbiter: RTL

//   Shares one TL-UL slave socket between NUM_MASTERS master sockets on the clk_100 domain.
//   A channel: round-robin arbiter with a hold lock, so a granted request stays stable until
//   it handshakes. Slave-side source = {master index, master source}.
//   D channel: responses are routed back by the index bits. A per-master outstanding counter

---
 rtl/tlul_a_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/tlul_a_arbiter.sv
// TL-UL A-channel arbiter: N master sockets share one slave socket with round-robin
// grant and hold lock; D responses are routed back by the index bits in the source.
module tlul_a_arbiter #(
   parameter int unsigned NUM_MASTERS     = 2,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned SIZE_WIDTH      = 3,
   parameter int unsigned SRC_WIDTH       = 1,
   parameter int unsigned OPCODE_WIDTH    = 3,
   parameter int unsigned PARAM_WIDTH     = 3,
   parameter int unsigned SINK_WIDTH      = 1,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                         clk_100,
   input  logic                                         reset_n,
   input  logic [NUM_MASTERS-1:0]                       m_a_valid,
   output logic [NUM_MASTERS-1:0]                       m_a_ready,
   input  logic [NUM_MASTERS*OPCODE_WIDTH-1:0]          m_a_opcode,
   input  logic [NUM_MASTERS*PARAM_WIDTH-1:0]           m_a_param,
   input  logic [NUM_MASTERS*SIZE_WIDTH-1:0]            m_a_size,
   input  logic [NUM_MASTERS*SRC_WIDTH-1:0]             m_a_source,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]            m_a_address,
   input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]        m_a_mask,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]            m_a_data,
   output logic [NUM_MASTERS-1:0]                       m_d_valid,
   input  logic [NUM_MASTERS-1:0]                       m_d_ready,
   output logic [OPCODE_WIDTH-1:0]                      m_d_opcode,
   output logic [PARAM_WIDTH-1:0]                       m_d_param,
   output logic [SIZE_WIDTH-1:0]                        m_d_size,
   output logic [SRC_WIDTH-1:0]                         m_d_source,
   output logic [SINK_WIDTH-1:0]                        m_d_sink,
   output logic [DATA_WIDTH-1:0]                        m_d_data,
   output logic                                         m_d_error,
   output logic                                         s_a_valid,
   input  logic                                         s_a_ready,
   output logic [OPCODE_WIDTH-1:0]                      s_a_opcode,
   output logic [PARAM_WIDTH-1:0]                       s_a_param,
   output logic [SIZE_WIDTH-1:0]                        s_a_size,
   output logic [SRC_WIDTH+$clog2(NUM_MASTERS)-1:0]     s_a_source,
   output logic [ADDR_WIDTH-1:0]                        s_a_address,
   output logic [DATA_WIDTH/8-1:0]                      s_a_mask,
   output logic [DATA_WIDTH-1:0]                        s_a_data,
   input  logic                                         s_d_valid,
   output logic                                         s_d_ready,
   input  logic [OPCODE_WIDTH-1:0]                      s_d_opcode,
   input  logic [PARAM_WIDTH-1:0]                       s_d_param,
   input  logic [SIZE_WIDTH-1:0]                        s_d_size,
   input  logic [SRC_WIDTH+$clog2(NUM_MASTERS)-1:0]     s_d_source,
   input  logic [SINK_WIDTH-1:0]                        s_d_sink,
   input  logic [DATA_WIDTH-1:0]                        s_d_data,
   input  logic                                         s_d_error,
   output logic                                         err_unexpected_d
);

   localparam int unsigned IDX_W  = $clog2(NUM_MASTERS);
   localparam int unsigned MASK_W = DATA_WIDTH / 8;
   localparam int unsigned SS_W   = SRC_WIDTH + IDX_W;
   localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                 state;
   logic [IDX_W-1:0]       rr_ptr;
   logic [IDX_W-1:0]       grant_q;
   logic [IDX_W-1:0]       grant_idx;
   logic [IDX_W-1:0]       cand;
   logic                   grant_vld;
   logic [IDX_W-1:0]       d_idx;
   logic [CNT_W-1:0]       cnt [NUM_MASTERS];
   logic [NUM_MASTERS-1:0] eligible;
   logic [NUM_MASTERS-1:0] a_hs;
   logic [NUM_MASTERS-1:0] d_hs;
   logic                   err_q;

   always_comb begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++)
         eligible[i] = m_a_valid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
   end

   // Reset gating keeps every valid/ready output low while reset_n is asserted.
   always_comb begin
      grant_idx = '0;
      grant_vld = 1'b0;
      cand      = '0;
      if (reset_n) begin
         if (state == LOCKED) begin
            grant_idx = grant_q;
            grant_vld = 1'b1;
         end else begin
            for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
               cand = rr_ptr + IDX_W'(off);
               if (!grant_vld && eligible[cand]) begin
                  grant_idx = cand;
                  grant_vld = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      s_a_valid   = grant_vld;
      s_a_opcode  = '0;
      s_a_param   = '0;
      s_a_size    = '0;
      s_a_source  = '0;
      s_a_address = '0;
      s_a_mask    = '0;
      s_a_data    = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++)
         m_a_ready[i] = grant_vld && (grant_idx == IDX_W'(i)) && s_a_ready;
      if (grant_vld) begin
         s_a_opcode  = m_a_opcode [int'(grant_idx)*OPCODE_WIDTH +: OPCODE_WIDTH];
         s_a_param   = m_a_param  [int'(grant_idx)*PARAM_WIDTH  +: PARAM_WIDTH];
         s_a_size    = m_a_size   [int'(grant_idx)*SIZE_WIDTH   +: SIZE_WIDTH];
         s_a_source  = {grant_idx, m_a_source[int'(grant_idx)*SRC_WIDTH +: SRC_WIDTH]};
         s_a_address = m_a_address[int'(grant_idx)*ADDR_WIDTH   +: ADDR_WIDTH];
         s_a_mask    = m_a_mask   [int'(grant_idx)*MASK_W       +: MASK_W];
         s_a_data    = m_a_data   [int'(grant_idx)*DATA_WIDTH   +: DATA_WIDTH];
      end
   end

   always_comb begin
      d_idx     = s_d_source[SS_W-1:SRC_WIDTH];
      m_d_valid = '0;
      s_d_ready = 1'b0;
      if (reset_n) begin
         m_d_valid[d_idx] = s_d_valid;
         s_d_ready        = m_d_ready[d_idx];
      end
      a_hs = m_a_ready;
      d_hs = m_d_valid & {NUM_MASTERS{s_d_ready}};
   end

   assign m_d_opcode       = s_d_opcode;
   assign m_d_param        = s_d_param;
   assign m_d_size         = s_d_size;
   assign m_d_source       = s_d_source[SRC_WIDTH-1:0];
   assign m_d_sink         = s_d_sink;
   assign m_d_data         = s_d_data;
   assign m_d_error        = s_d_error;
   assign err_unexpected_d = err_q;

   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         grant_q <= '0;
         err_q   <= 1'b0;
         for (int unsigned i = 0; i < NUM_MASTERS; i++)
            cnt[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  if (s_a_ready) begin
                     rr_ptr <= grant_idx + 1'b1;
                  end else begin
                     grant_q <= grant_idx;
                     state   <= LOCKED;
                  end
               end
            end
            LOCKED: begin
               if (s_a_ready) begin
                  rr_ptr <= grant_q + 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // A response to an idle master is still forwarded; only the sticky flag records it.
         for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (a_hs[i] && !d_hs[i]) begin
               if (cnt[i] != CNT_W'(MAX_OUTSTANDING))
                  cnt[i] <= cnt[i] + 1'b1;
            end else if (d_hs[i] && !a_hs[i] && (cnt[i] != '0)) begin
               cnt[i] <= cnt[i] - 1'b1;
            end
            if (d_hs[i] && (cnt[i] == '0))
               err_q <= 1'b1;
         end
      end
   end

endmodule
